bmp_uploader: RTL

BMP_UPLOADER -- requirements
Module: bmp_uploader

---
 rtl/bmp_uploader.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/bmp_uploader.sv
// bmp_uploader: streams a frame buffer out as a 24-bit bottom-up BMP file.
// A fixed 54-byte header comes first, then one B,G,R byte triple per pixel,
// each pixel fetched from memory as 0x00RRGGBB just before its bytes go out.
// Ports:
//   clk_sys, reset      clock, synchronous active-high reset
//   ioctl_upload        high for the whole transfer; its rising edge starts one
//   ioctl_rd            strobe: current byte consumed
//   ioctl_din, ready    byte for the current offset and its valid flag
//   mem_rd, mem_addr    one-cycle word read request and word address
//   mem_q, mem_valid    read data and its one-cycle valid pulse
module bmp_uploader #(
  parameter int          H_PIX = 640,
  parameter int          V_PIX = 312,
  parameter logic [21:0] BASE  = 22'h0
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_upload,
  input  logic        ioctl_rd,
  output logic [7:0]  ioctl_din,
  output logic        ready,
  output logic        mem_rd,
  output logic [21:0] mem_addr,
  input  logic [31:0] mem_q,
  input  logic        mem_valid
);

  localparam logic [31:0] IMG_SZ     = 32'(H_PIX * V_PIX * 3);
  localparam logic [31:0] FILE_SZ    = IMG_SZ + 32'd54;
  localparam logic [15:0] COL_LAST   = 16'(H_PIX - 1);
  localparam logic [15:0] ROW_LAST   = 16'(V_PIX - 1);
  // File row 0 is the bottom frame line.
  localparam logic [21:0] ADDR_FIRST = BASE + 22'((V_PIX - 1) * H_PIX);
  // From the last column of a line back to column 0 of the line above it.
  localparam logic [21:0] ROW_STEP   = 22'(2 * H_PIX - 1);

  typedef enum logic [2:0] {IDLE, HDR, FETCH, WAIT, PIX, DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  off_q, off_d;
  logic [1:0]  phase_q, phase_d;
  logic [15:0] col_q, col_d;
  logic [15:0] row_q, row_d;
  logic [21:0] addr_q, addr_d;
  logic [23:0] pix_q, pix_d;
  logic [7:0]  din_q, din_d;
  logic        ready_q, ready_d;
  logic        upload_q;
  logic        rd_ok;

  // Header byte at a given offset; each field is read little-endian.
  function automatic logic [7:0] hdr_byte(input logic [5:0] off);
    logic [31:0] w;
    logic [5:0]  rel;
    w   = '0;
    rel = '0;
    if      (off < 6'd2)  begin w = 32'h0000_4D42; rel = off;          end
    else if (off < 6'd6)  begin w = FILE_SZ;       rel = off - 6'd2;   end
    else if (off < 6'd10) begin w = 32'd0;         rel = off - 6'd6;   end
    else if (off < 6'd14) begin w = 32'd54;        rel = off - 6'd10;  end
    else if (off < 6'd18) begin w = 32'd40;        rel = off - 6'd14;  end
    else if (off < 6'd22) begin w = 32'(H_PIX);    rel = off - 6'd18;  end
    else if (off < 6'd26) begin w = 32'(V_PIX);    rel = off - 6'd22;  end
    else if (off < 6'd28) begin w = 32'd1;         rel = off - 6'd26;  end
    else if (off < 6'd30) begin w = 32'd24;        rel = off - 6'd28;  end
    else if (off < 6'd34) begin w = 32'd0;         rel = off - 6'd30;  end
    else if (off < 6'd38) begin w = IMG_SZ;        rel = off - 6'd34;  end
    else if (off < 6'd42) begin w = 32'd2835;      rel = off - 6'd38;  end
    else if (off < 6'd46) begin w = 32'd2835;      rel = off - 6'd42;  end
    else                  begin w = 32'd0;         rel = 6'd0;         end
    return w[{rel[1:0], 3'b000} +: 8];
  endfunction

  // Strobes are honoured only while the current byte is valid.
  assign rd_ok = ioctl_rd & ready_q;

  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    phase_d = phase_q;
    col_d   = col_q;
    row_d   = row_q;
    addr_d  = addr_q;
    pix_d   = pix_q;
    din_d   = din_q;
    ready_d = ready_q;

    case (state_q)
      IDLE: begin
        din_d   = 8'h00;
        ready_d = 1'b0;
        if (ioctl_upload && !upload_q) begin
          state_d = HDR;
          off_d   = 6'd0;
          phase_d = 2'd0;
          col_d   = 16'd0;
          row_d   = 16'd0;
          din_d   = hdr_byte(6'd0);
          ready_d = 1'b1;
        end
      end
      HDR: begin
        if (rd_ok) begin
          if (off_q == 6'd53) begin
            state_d = FETCH;
            ready_d = 1'b0;
            addr_d  = ADDR_FIRST;
          end else begin
            off_d = off_q + 6'd1;
            din_d = hdr_byte(off_q + 6'd1);
          end
        end
      end
      FETCH: state_d = WAIT;
      WAIT: begin
        if (mem_valid) begin
          pix_d   = mem_q[23:0];
          din_d   = mem_q[7:0];
          ready_d = 1'b1;
          phase_d = 2'd0;
          state_d = PIX;
        end
      end
      PIX: begin
        if (rd_ok) begin
          case (phase_q)
            2'd0: begin phase_d = 2'd1; din_d = pix_q[15:8];  end
            2'd1: begin phase_d = 2'd2; din_d = pix_q[23:16]; end
            default: begin
              phase_d = 2'd0;
              if (col_q == COL_LAST && row_q == ROW_LAST) begin
                state_d = DONE;
                din_d   = 8'h00;
              end else begin
                state_d = FETCH;
                ready_d = 1'b0;
                if (col_q == COL_LAST) begin
                  col_d  = 16'd0;
                  row_d  = row_q + 16'd1;
                  addr_d = addr_q - ROW_STEP;
                end else begin
                  col_d  = col_q + 16'd1;
                  addr_d = addr_q + 22'd1;
                end
              end
            end
          endcase
        end
      end
      DONE: begin
        din_d   = 8'h00;
        ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Dropping upload aborts from anywhere, taking priority over a same-cycle strobe.
    if (state_q != IDLE && !ioctl_upload) begin
      state_d = IDLE;
      off_d   = 6'd0;
      phase_d = 2'd0;
      col_d   = 16'd0;
      row_d   = 16'd0;
      addr_d  = BASE;
      din_d   = 8'h00;
      ready_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    // upload_q tracks the pin even in reset so a level held through reset
    // is not mistaken for a new rising edge.
    upload_q <= ioctl_upload;
    if (reset) begin
      state_q <= IDLE;
      off_q   <= '0;
      phase_q <= '0;
      col_q   <= '0;
      row_q   <= '0;
      addr_q  <= BASE;
      pix_q   <= '0;
      din_q   <= 8'h00;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      phase_q <= phase_d;
      col_q   <= col_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      pix_q   <= pix_d;
      din_q   <= din_d;
      ready_q <= ready_d;
    end
  end

  assign ioctl_din = din_q;
  assign ready     = ready_q;
  assign mem_rd    = (state_q == FETCH);
  assign mem_addr  = addr_q;

endmodule
